// File: rtl/pc_redirect_unit.sv
// Next-PC stage: resolves B-type/JAL/JALR redirects, owns the fetch PC,
// and presents it to fetch through a valid/ready handshake.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_instr_valid,
   input  logic [31:0] i_instr_pc,
   input  logic [2:0]  i_funct,
   input  logic        i_b,
   input  logic        i_j,
   input  logic        i_jr,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_rs1_data,
   input  logic        i_br_eq,
   input  logic        i_br_lt,
   input  logic        i_work,
   input  logic        i_fetch_ready,
   output logic [31:0] o_pc,
   output logic        o_pc_valid,
   output logic        o_flush,
   output logic        o_taken,
   output logic        o_misalign,
   output logic        o_bad_funct,
   output logic [31:0] o_link_data
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2
   } state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic        r_taken;
   logic        w_taken_nxt;
   logic        r_misalign;
   logic        w_misalign_nxt;
   logic        r_bad_funct;
   logic        w_bad_funct_nxt;

   logic        w_resolve;
   logic        w_sel_jr;
   logic        w_sel_j;
   logic        w_sel_b;
   logic        w_br_cond;
   logic        w_funct_bad;
   logic        w_br_taken;
   logic        w_redirect;
   logic [31:0] w_jalr_sum;
   logic [31:0] w_target;
   logic        w_target_misaligned;

   // Resolve only in RUN; IDLE/FLUSH instructions are wrong-path.
   assign w_resolve = (r_state == StRun) && i_instr_valid;

   // Priority JR > J > B when several decode flags are set.
   assign w_sel_jr = i_jr;
   assign w_sel_j  = !i_jr && i_j;
   assign w_sel_b  = !i_jr && !i_j && i_b;

   // Decode the branch condition from funct3; 010/011 are not valid branches.
   always_comb begin
      w_br_cond   = 1'b0;
      w_funct_bad = 1'b0;
      case (i_funct)
         3'b000:          w_br_cond = i_br_eq;
         3'b001:          w_br_cond = !i_br_eq;
         3'b100, 3'b110:  w_br_cond = i_br_lt;
         3'b101, 3'b111:  w_br_cond = !i_br_lt;
         default:         w_funct_bad = 1'b1;
      endcase
   end

   // The comparator drives BrEq/BrLT high when idle, so work gates the result.
   assign w_br_taken = w_sel_b && i_work && w_br_cond;
   assign w_redirect = w_resolve && (w_sel_jr || w_sel_j || w_br_taken);

   assign w_jalr_sum          = i_rs1_data + i_imm;
   assign w_target            = w_sel_jr ? (w_jalr_sum & ~32'h1) : (i_instr_pc + i_imm);
   assign w_target_misaligned = (w_target[1:0] != 2'b00);

   // Next-state, next-PC and pulse generation.
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_taken_nxt     = 1'b0;
      w_misalign_nxt  = 1'b0;
      w_bad_funct_nxt = 1'b0;
      case (r_state)
         StIdle: begin
            w_state_nxt = StRun;
         end
         StRun: begin
            w_bad_funct_nxt = w_resolve && w_sel_b && w_funct_bad;
            if (w_redirect) begin
               // A trap also discards the in-flight fetch, so it flushes too.
               w_state_nxt = StFlush;
               if (w_target_misaligned) begin
                  w_pc_nxt       = TRAP_VEC;
                  w_misalign_nxt = 1'b1;
               end else begin
                  w_pc_nxt    = w_target;
                  w_taken_nxt = 1'b1;
               end
            end else if (i_fetch_ready) begin
               w_pc_nxt = r_pc + 32'd4;
            end
         end
         StFlush: begin
            w_state_nxt = StRun;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State, PC and pulse registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_pc        <= RESET_PC;
         r_taken     <= 1'b0;
         r_misalign  <= 1'b0;
         r_bad_funct <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_taken     <= w_taken_nxt;
         r_misalign  <= w_misalign_nxt;
         r_bad_funct <= w_bad_funct_nxt;
      end
   end

   assign o_pc        = r_pc;
   assign o_pc_valid  = (r_state == StRun);
   assign o_flush     = (r_state == StFlush);
   assign o_taken     = r_taken;
   assign o_misalign  = r_misalign;
   assign o_bad_funct = r_bad_funct;
   assign o_link_data = i_instr_pc + 32'd4;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: the driver queues the expected
// outputs for each cycle; a monitor checks them mid-cycle.
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [2:0]  funct;
   logic        b_f;
   logic        j_f;
   logic        jr_f;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        br_eq;
   logic        br_lt;
   logic        work;
   logic        fetch_ready;
   logic [31:0] pc;
   logic        pc_valid;
   logic        flush;
   logic        taken;
   logic        misalign;
   logic        bad_funct;
   logic [31:0] link_data;

   always #5 clk = ~clk;

   pc_redirect_unit dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_instr_valid (instr_valid),
      .i_instr_pc    (instr_pc),
      .i_funct       (funct),
      .i_b           (b_f),
      .i_j           (j_f),
      .i_jr          (jr_f),
      .i_imm         (imm),
      .i_rs1_data    (rs1_data),
      .i_br_eq       (br_eq),
      .i_br_lt       (br_lt),
      .i_work        (work),
      .i_fetch_ready (fetch_ready),
      .o_pc          (pc),
      .o_pc_valid    (pc_valid),
      .o_flush       (flush),
      .o_taken       (taken),
      .o_misalign    (misalign),
      .o_bad_funct   (bad_funct),
      .o_link_data   (link_data)
   );

   // {pc, pc_valid, flush, taken, misalign, bad_funct, link_data}
   typedef struct {
      string       name;
      logic [68:0] exp;
      logic [68:0] mask;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_e;
   logic [68:0] m_got;
   int          n_chk  = 0;
   int          n_pass = 0;

   // Monitor: compare the DUT against the oldest queued expectation.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m_e   = sb.pop_front();
         m_got = {pc, pc_valid, flush, taken, misalign, bad_funct, link_data};
         n_chk++;
         if ((m_got & m_e.mask) == (m_e.exp & m_e.mask)) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got pc=%h v=%b fl=%b tk=%b ms=%b bf=%b link=%h; required pc=%h v=%b fl=%b tk=%b ms=%b bf=%b link=%h (mask %h)",
                     m_e.name, m_got[68:37], m_got[36], m_got[35], m_got[34], m_got[33],
                     m_got[32], m_got[31:0], m_e.exp[68:37], m_e.exp[36], m_e.exp[35],
                     m_e.exp[34], m_e.exp[33], m_e.exp[32], m_e.exp[31:0], m_e.mask);
         end
      end
   end

   // Queue this cycle's expected outputs, then advance to just after the next edge.
   task automatic step(input string nm, input logic [31:0] e_pc, input logic e_v,
                       input logic e_fl, input logic e_tk, input logic e_ms, input logic e_bf,
                       input bit care_vf = 1'b1);
      exp_t e;
      e.name = nm;
      e.exp  = {e_pc, e_v, e_fl, e_tk, e_ms, e_bf, instr_pc + 32'd4};
      e.mask = {32'hFFFF_FFFF, care_vf, care_vf, 3'b111, 32'hFFFF_FFFF};
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Decode idle; comparator idle forces BrEq = BrLT = 1.
   task automatic clr();
      instr_valid = 1'b0;
      instr_pc    = 32'h0;
      funct       = 3'b000;
      b_f         = 1'b0;
      j_f         = 1'b0;
      jr_f        = 1'b0;
      imm         = 32'h0;
      rs1_data    = 32'h0;
      br_eq       = 1'b1;
      br_lt       = 1'b1;
      work        = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      fetch_ready = 1'b1;
      clr();
      @(posedge clk);
      #1;

      // Reset and sequential advance
      step("reset",   32'h0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step("idle",    32'h0, 0, 0, 0, 0, 0);
      step("adv0",    32'h0, 1, 0, 0, 0, 0);
      step("adv4",    32'h4, 1, 0, 0, 0, 0);
      step("adv8",    32'h8, 1, 0, 0, 0, 0);
      step("adv12",   32'hC, 1, 0, 0, 0, 0);

      // BEQ taken: 0x40 + 0x20
      instr_valid = 1'b1; instr_pc = 32'h40; imm = 32'h20; b_f = 1'b1;
      funct = 3'b000; work = 1'b1; br_eq = 1'b1; br_lt = 1'b0;
      step("beq_res", 32'h10, 1, 0, 0, 0, 0);
      clr();
      step("beq_fl",  32'h60, 0, 1, 1, 0, 0);
      step("beq_run", 32'h60, 1, 0, 0, 0, 0);

      // BGEU with BrLT=1: not taken, pc advances
      instr_valid = 1'b1; instr_pc = 32'h80; imm = 32'h10; b_f = 1'b1;
      funct = 3'b111; work = 1'b1; br_eq = 1'b0; br_lt = 1'b1;
      step("bgeu_res", 32'h64, 1, 0, 0, 0, 0);
      // JAL: 0x100 - 0x10
      clr();
      instr_valid = 1'b1; instr_pc = 32'h100; imm = 32'hFFFF_FFF0; j_f = 1'b1;
      step("jal_res", 32'h68, 1, 0, 0, 0, 0);
      clr();
      step("jal_fl",  32'hF0, 0, 1, 1, 0, 0);
      step("jal_run", 32'hF0, 1, 0, 0, 0, 0);

      // JALR with J and B also set: JR wins, bit 0 of 0x204 cleared -> 0x204
      instr_valid = 1'b1; instr_pc = 32'h200; imm = 32'h1; rs1_data = 32'h203;
      jr_f = 1'b1; j_f = 1'b1; b_f = 1'b1; work = 1'b1;
      step("jalr_res", 32'hF4, 1, 0, 0, 0, 0);
      clr();
      step("jalr_fl",  32'h204, 0, 1, 1, 0, 0);
      step("jalr_run", 32'h204, 1, 0, 0, 0, 0);

      // JALR to 0x202: misaligned, trap to 0x100
      instr_valid = 1'b1; instr_pc = 32'h300; imm = 32'h0; rs1_data = 32'h202; jr_f = 1'b1;
      step("mis_res", 32'h208, 1, 0, 0, 0, 0);
      clr();
      fetch_ready = 1'b0;
      step("mis_trap", 32'h100, 0, 0, 0, 1, 0, 1'b0);

      // Stall: fetch_ready low, pc holds
      step("stall1", 32'h100, 1, 0, 0, 0, 0);
      step("stall2", 32'h100, 1, 0, 0, 0, 0);
      step("stall3", 32'h100, 1, 0, 0, 0, 0);

      // BNE taken together with a fetch handshake: redirect wins
      fetch_ready = 1'b1;
      instr_valid = 1'b1; instr_pc = 32'h400; imm = 32'h40; b_f = 1'b1;
      funct = 3'b001; work = 1'b1; br_eq = 1'b0; br_lt = 1'b0;
      step("bne_res", 32'h100, 1, 0, 0, 0, 0);
      clr();
      step("bne_fl",  32'h440, 0, 1, 1, 0, 0);
      step("bne_run", 32'h440, 1, 0, 0, 0, 0);

      // B with work=0 (comparator idle values): not taken
      instr_valid = 1'b1; instr_pc = 32'h500; imm = 32'h8; b_f = 1'b1; funct = 3'b000;
      step("nowork_res", 32'h444, 1, 0, 0, 0, 0);

      // funct3 = 010: bad_funct, no redirect
      clr();
      instr_valid = 1'b1; instr_pc = 32'h600; imm = 32'h8; b_f = 1'b1;
      funct = 3'b010; work = 1'b1;
      step("bad_res", 32'h448, 1, 0, 0, 0, 0);
      clr();
      step("bad_flag", 32'h44C, 1, 0, 0, 0, 1);

      // JAL to 0xFFFF_FFFC, then wrap to 0
      instr_valid = 1'b1; instr_pc = 32'h10; imm = 32'hFFFF_FFEC; j_f = 1'b1;
      step("wrap_res", 32'h450, 1, 0, 0, 0, 0);
      clr();
      step("wrap_fl",  32'hFFFF_FFFC, 0, 1, 1, 0, 0);
      step("wrap_top", 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
      step("wrap_0",   32'h0, 1, 0, 0, 0, 0);

      // BLT taken backwards: 0x700 - 0x100, then reset during FLUSH
      instr_valid = 1'b1; instr_pc = 32'h700; imm = 32'hFFFF_FF00; b_f = 1'b1;
      funct = 3'b100; work = 1'b1; br_eq = 1'b0; br_lt = 1'b1;
      step("blt_res", 32'h4, 1, 0, 0, 0, 0);
      clr();
      rst_n = 1'b0;
      step("rst_in_flush", 32'h0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step("rst_idle",     32'h0, 0, 0, 0, 0, 0);
      step("rst_run",      32'h0, 1, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
